keccak_round_sequencer: RTL and testbench
=========================================

Name: keccak_round_sequencer

Overview:
Top-level controller for the encoder permutation datapath. It sequences the five step modules (theta, rho/rotate, pi, chi, iota) through NUM_ROUNDS rounds for each input file. It drives each step's start/file_index handshake in the same way a bench drives a single step: start is held high for a fixed number of cycles, then the sequencer waits for that step's finish. It replaces per-step benches as the driver of a full encode run.

Parameters:
NUM_STEPS, 5, number of step modules sequenced per round (index 0 = theta … 4 = iota)
NUM_ROUNDS, 24, rounds per file
FILE_FIRST, 1, first file_index value
FILE_LAST, 2, last file_index value (inclusive)
START_HOLD, 3, cycles step_start stays high per launch
TIMEOUT, 4096, max cycles to wait for a step finish before error

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a full run; sampled in IDLE only
step_finish  input  NUM_STEPS  finish flag from each step module, level or pulse
step_start  output  NUM_STEPS  one-hot start to current step module
file_index  output  10  file index presented to all step modules
round_index  output  5  current round (0..NUM_ROUNDS-1), for iota RC selection
busy  output  1  high from run accept until DONE
finish  output  1  one-cycle pulse at run completion
error  output  1  sticky timeout flag; cleared by rst or next accepted start

Behaviour:
- Reset (async, any time incl. mid-run): state=IDLE; step_start=0, file_index=FILE_FIRST, round_index=0, busy=0, finish=0, error=0; hold/timeout counters=0.
- States: IDLE, LAUNCH, WAIT, ADVANCE, DONE.
- IDLE: on start=1, load file_index=FILE_FIRST, round_index=0, step=0, clear error, busy=1, go to LAUNCH. start=0 → stay.
- LAUNCH: step_start[step]=1 (only that bit) for exactly START_HOLD cycles (hold counter), then → WAIT with step_start=0. step_finish ignored during LAUNCH, so a stale finish from the previous use is never taken.
- WAIT: timeout counter increments each cycle. On step_finish[step]=1 → ADVANCE. Other step_finish bits are ignored. If counter reaches TIMEOUT → error=1, then DONE (abort run).
- ADVANCE (1 cycle):
  - If step<NUM_STEPS-1: step+1.
  - Else step=0; if round_index<NUM_ROUNDS-1, round_index+1.
  - Else round_index=0; if file_index<FILE_LAST, file_index+1.
  - Else → DONE.
  - Otherwise → LAUNCH.
- DONE (1 cycle): finish=1, busy=0 next cycle, → IDLE; file_index retains last value.
- Latency: start sampled at edge k; step_start[0] is high for edges k+1..k+START_HOLD. Each step costs START_HOLD + (step latency after hold) + 1 ADVANCE cycle.
- file_index and round_index change only in ADVANCE, never while step_start or WAIT is active.
- start asserted while busy: ignored (no restart, no queueing).
- step_finish asserted in the same cycle LAUNCH ends: not accepted; it must still be high (or re-assert) in WAIT.
- Wrap rules: the step, round and file counters never exceed their bounds. round_index is 5 bits; NUM_ROUNDS ≤ 32 is required.

Test Plan:
- Single run, stub steps finish 4 cycles after start falls: pulse start → 2 files × 24 rounds × 5 launches = 240 one-hot step_start pulses of exactly 3 cycles, in order 0,1,2,3,4. round_index counts 0..23 twice; file_index 1 then 2. One finish pulse; busy low afterwards; error=0.
- Stale finish: hold step_finish[1]=1 throughout LAUNCH of step 1 → no advance until WAIT; the step 1 launch still lasts 3 cycles.
- Timeout: step 2 stub never finishes with TIMEOUT=16 → error=1 sixteen cycles into WAIT; finish pulses; busy=0. The next start clears error.
- Reset mid-run: assert rst during round 7, step 3 → all outputs return to reset values immediately (async); a subsequent start restarts at file 1, round 0, step 0.
- start while busy: pulse start during round 3 → no state change; total launch count is still 240.
- Wrong-bit finish: assert step_finish[4] while waiting on step 0 → ignored; the sequencer advances only on step_finish[0].

Source files
------------

// File: rtl/keccak_round_sequencer.sv
// Keccak round sequencer: walks the five permutation step modules
// (theta, rho, pi, chi, iota) through NUM_ROUNDS rounds for every file
// index in FILE_FIRST..FILE_LAST, using a start-hold / wait-for-finish
// handshake per step, with a per-step timeout that aborts the run.
module keccak_round_sequencer #(
    parameter int NUM_STEPS  = 5,
    parameter int NUM_ROUNDS = 24,
    parameter int FILE_FIRST = 1,
    parameter int FILE_LAST  = 2,
    parameter int START_HOLD = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_STEPS-1:0] step_finish,
    output logic [NUM_STEPS-1:0] step_start,
    output logic [9:0]           file_index,
    output logic [4:0]           round_index,
    output logic                 busy,
    output logic                 finish,
    output logic                 error
);

    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int HOLD_W = $clog2(START_HOLD + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(NUM_STEPS - 1);
    localparam logic [4:0]        ROUND_LAST = 5'(NUM_ROUNDS - 1);
    localparam logic [9:0]        FILE_INIT  = 10'(FILE_FIRST);
    localparam logic [9:0]        FILE_END   = 10'(FILE_LAST);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(START_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ADVANCE,
        DONE
    } state_t;

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TO_W-1:0]     wait_cnt;

    // One-hot select for the step module being launched.
    function automatic logic [NUM_STEPS-1:0] onehot(input logic [STEP_W-1:0] idx);
        return NUM_STEPS'(1) << idx;
    endfunction

    // Sequencer FSM with every output registered.
    // NOTE: all state and outputs use non-blocking assignments so every
    // right-hand side reads the pre-edge value, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
            step_start  <= '0;
            file_index  <= FILE_INIT;
            round_index <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    finish <= 1'b0;
                    if (start) begin
                        file_index  <= FILE_INIT;
                        round_index <= '0;
                        step        <= '0;
                        hold_cnt    <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        step_start  <= onehot('0);
                        state       <= LAUNCH;
                    end
                end

                // step_finish is deliberately not looked at here, so a
                // finish left over from the previous launch cannot be taken.
                LAUNCH: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt   <= '0;
                        wait_cnt   <= '0;
                        step_start <= '0;
                        state      <= WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                WAIT: begin
                    if (step_finish[step]) begin
                        wait_cnt <= '0;
                        state    <= ADVANCE;
                    end else if (wait_cnt == TO_LAST) begin
                        wait_cnt <= '0;
                        error    <= 1'b1;
                        finish   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ADVANCE: begin
                    if (step != STEP_LAST) begin
                        step       <= step + 1'b1;
                        step_start <= onehot(step + 1'b1);
                        state      <= LAUNCH;
                    end else begin
                        step <= '0;
                        if (round_index != ROUND_LAST) begin
                            round_index <= round_index + 1'b1;
                            step_start  <= onehot('0);
                            state       <= LAUNCH;
                        end else begin
                            round_index <= '0;
                            if (file_index < FILE_END) begin
                                file_index <= file_index + 1'b1;
                                step_start <= onehot('0);
                                state      <= LAUNCH;
                            end else begin
                                finish <= 1'b1;
                                state  <= DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Directed bench for keccak_round_sequencer: stub step modules that finish
// a few cycles after their start falls, a launch monitor with a small
// step/round/file model, and directed scenarios for stale finish, timeout,
// async reset mid-run, start while busy and wrong-bit finish.
module tb_keccak_round_sequencer;

    localparam int NS = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NS-1:0] step_finish;
    logic [NS-1:0] step_start;
    logic [9:0]    file_index;
    logic [4:0]    round_index;
    logic          busy;
    logic          finish;
    logic          error;

    logic [NS-1:0] auto_fin  = '0;
    logic [NS-1:0] extra_fin = '0;
    logic [NS-1:0] kill      = '0;
    assign step_finish = auto_fin | extra_fin;

    int total = 0;
    int bad   = 0;

    // monitor / model state
    logic          mon_en = 1'b0;
    int            exp_step, exp_round, exp_file;
    int            launch_cnt, finish_cnt;

    keccak_round_sequencer #(
        .NUM_STEPS (NS),
        .NUM_ROUNDS(24),
        .FILE_FIRST(1),
        .FILE_LAST (2),
        .START_HOLD(3),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_finish(step_finish),
        .step_start (step_start),
        .file_index (file_index),
        .round_index(round_index),
        .busy       (busy),
        .finish     (finish),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_step   = 0;
        exp_round  = 0;
        exp_file   = 1;
        launch_cnt = 0;
        finish_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run_end(input string tag);
        int n = 0;
        while (!finish && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(finish), 1);
    endtask

    // Stub steps: one-cycle finish four cycles after that step's start falls.
    initial begin
        logic [NS-1:0] prev = '0;
        int cnt [NS];
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if (prev[i] && !step_start[i]) cnt[i] = 4;
                else if (cnt[i] != 0) cnt[i]--;
                auto_fin[i] = (cnt[i] == 1) && !kill[i];
            end
            prev = step_start;
        end
    end

    // Launch monitor: checks order, indices and hold length of every pulse.
    initial begin
        logic [NS-1:0] prev = '0;
        int len = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = '0;
                len  = 0;
            end else begin
                if (step_start != prev) begin
                    if (prev != '0) check("hold_len", len, 3);
                    if (step_start != '0) begin
                        check("launch_bit", 32'(step_start), 32'(1) << exp_step);
                        check("launch_round", 32'(round_index), exp_round);
                        check("launch_file", 32'(file_index), exp_file);
                        launch_cnt++;
                        len = 1;
                        exp_step++;
                        if (exp_step == NS) begin
                            exp_step = 0;
                            exp_round++;
                            if (exp_round == 24) begin
                                exp_round = 0;
                                exp_file++;
                            end
                        end
                    end
                end else if (step_start != '0) begin
                    len++;
                end
                if (finish) finish_cnt++;
                prev = step_start;
            end
        end
    end

    initial begin
        int n;
        start = 1'b0;
        rst   = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_step_start", 32'(step_start), 0);
        check("rst_file", 32'(file_index), 1);
        check("rst_round", 32'(round_index), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_finish", 32'(finish), 0);
        check("rst_error", 32'(error), 0);
        rst = 1'b0;

        // ---- Run 1: clean full run ----
        mon_en = 1'b1;
        pulse_start();
        check("r1_busy", 32'(busy), 1);
        wait_run_end("r1_done");
        check("r1_err", 32'(error), 0);
        @(negedge clk);
        check("r1_busy_after", 32'(busy), 0);
        check("r1_finish_1cyc", 32'(finish), 0);
        check("r1_file_kept", 32'(file_index), 2);
        check("r1_round_end", 32'(round_index), 0);
        check("r1_launches", launch_cnt, 240);
        check("r1_finishes", finish_cnt, 1);

        // ---- Run 2: step 2 never finishes -> timeout ----
        model_reset();
        kill = 5'b00100;
        pulse_start();
        n = 0;
        while (!step_start[2] && n < 200) begin @(negedge clk); n++; end
        check("r2_saw_step2", 32'(step_start[2]), 1);
        while (step_start[2] && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!error && n < 40) begin @(negedge clk); n++; end
        check("r2_timeout_cycles", n, TO);
        check("r2_finish", 32'(finish), 1);
        check("r2_busy_at_finish", 32'(busy), 1);
        @(negedge clk);
        check("r2_busy_after", 32'(busy), 0);
        check("r2_error_sticky", 32'(error), 1);
        check("r2_launches", launch_cnt, 3);
        kill = '0;

        // ---- Run 3: start clears error; async reset in round 7 step 3 ----
        model_reset();
        pulse_start();
        check("r3_error_cleared", 32'(error), 0);
        check("r3_busy", 32'(busy), 1);
        n = 0;
        while (!(round_index == 5'd7 && step_start[3]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("r3_reached_r7s3", 32'(step_start[3]), 1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("r3_rst_step_start", 32'(step_start), 0);
        check("r3_rst_round", 32'(round_index), 0);
        check("r3_rst_file", 32'(file_index), 1);
        check("r3_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // ---- Run 4: wrong-bit finish, stale finish, start while busy ----
        model_reset();
        mon_en = 1'b1;
        kill   = 5'b00001;
        pulse_start();
        n = 0;
        while (!step_start[0] && n < 20) begin @(negedge clk); n++; end
        while (step_start[0] && n < 20) begin @(negedge clk); n++; end
        extra_fin[4] = 1'b1;
        repeat (8) @(negedge clk);
        check("r4_wrongbit_no_adv", 32'(step_start), 0);
        check("r4_wrongbit_busy", 32'(busy), 1);
        extra_fin[4] = 1'b0;
        extra_fin[0] = 1'b1;
        @(negedge clk);
        extra_fin[0] = 1'b0;
        kill = '0;
        n = 0;
        while (!step_start[1] && n < 20) begin @(negedge clk); n++; end
        extra_fin[1] = 1'b1;
        n = 0;
        while (!step_start[2] && n < 20) begin @(negedge clk); n++; end
        check("r4_stale_gap", n, 5);
        extra_fin[1] = 1'b0;
        n = 0;
        while (round_index != 5'd3 && n < 2000) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_run_end("r4_done");
        @(negedge clk);
        check("r4_launches", launch_cnt, 240);
        check("r4_finishes", finish_cnt, 1);
        check("r4_err", 32'(error), 0);
        check("r4_busy_after", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
